// File: rtl/rgb_lut_remap.sv
// rgb_lut_remap: per-channel LUT colour remap with vsync-synchronous bank switch; readback port via RGB_LUT_REMAP_READBACK_EN.
// Fixed 2-cycle pixel latency; no pixel backpressure, LUT writes accepted only while lut_wr_ready is high.
module rgb_lut_remap #(
  parameter int CH_W      = 8,
  parameter int NUM_CH    = 3,
  parameter int BANK_BITS = 2
) (
  input  logic                   pixclk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] vid_pData_in,
  input  logic                   vid_valid_in,
  input  logic                   vid_vsync_in,
  input  logic                   bypass,
  input  logic                   invert,
  input  logic [BANK_BITS-1:0]   bank_req,
  output logic [NUM_CH*CH_W-1:0] vid_pData_out,
  output logic                   vid_valid_out,
  output logic                   vid_vsync_out,
  output logic [BANK_BITS-1:0]   bank_active,
  output logic                   init_busy,
  input  logic                   lut_wr_en,
  input  logic [1:0]             lut_wr_ch,
  input  logic [BANK_BITS-1:0]   lut_wr_bank,
  input  logic [CH_W-1:0]        lut_wr_addr,
  input  logic [CH_W-1:0]        lut_wr_data,
  output logic                   lut_wr_ready,
  input  logic                   lut_rd_en,
  output logic [CH_W-1:0]        lut_rd_data
);

  localparam int AW = BANK_BITS + CH_W;
  localparam int PW = NUM_CH * CH_W;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic B_IDLE  = 1'b0;
  localparam logic B_PEND  = 1'b1;

  logic           init_state;
  logic [AW-1:0]  init_cnt;

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      init_state <= ST_INIT;
      init_cnt   <= '0;
    end else if (init_state == ST_INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == LAST_ADDR)
        init_state <= ST_RUN;
    end
  end

  assign init_busy    = (init_state == ST_INIT);
  assign lut_wr_ready = (init_state == ST_RUN);

  // The identity sweep owns the write port while busy, so host writes are simply not selected.
  logic [AW-1:0]   wr_addr;
  logic [CH_W-1:0] wr_data;
  assign wr_addr = init_busy ? init_cnt : {lut_wr_bank, lut_wr_addr};
  assign wr_data = init_busy ? init_cnt[CH_W-1:0] : lut_wr_data;

  logic                 bank_state;
  logic [BANK_BITS-1:0] bank_pend;
  logic                 vsync_prev;
  logic                 vs_rise;

  assign vs_rise = vid_vsync_in & ~vsync_prev;

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      bank_state  <= B_IDLE;
      bank_pend   <= '0;
      bank_active <= '0;
      vsync_prev  <= 1'b0;
    end else begin
      vsync_prev <= vid_vsync_in;
      if (bank_state == B_IDLE) begin
        if (bank_req != bank_active) begin
          bank_pend  <= bank_req;
          bank_state <= B_PEND;
        end
      end else begin
        if (vs_rise) begin
          bank_active <= bank_pend;
          bank_state  <= B_IDLE;
        end else if (bank_req == bank_active) begin
          bank_state <= B_IDLE;
        end else begin
          bank_pend <= bank_req;
        end
      end
    end
  end

  logic [PW-1:0] lut_word;
  logic [PW-1:0] rd_word;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CH_W-1:0] mem [2**AW];
    logic [CH_W-1:0] lut_q;
    logic            ch_we;

    // A channel index beyond NUM_CH matches no instance, so such writes fall away.
    assign ch_we = init_busy | (lut_wr_en & (lut_wr_ch == 2'(i)));

    always_ff @(posedge pixclk) begin
      if (ch_we)
        mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge pixclk or posedge rst) begin
      if (rst)
        lut_q <= '0;
      else
        lut_q <= mem[{bank_active, vid_pData_in[i*CH_W +: CH_W]}];
    end

    assign lut_word[i*CH_W +: CH_W] = lut_q;

`ifdef RGB_LUT_REMAP_READBACK_EN
    logic [CH_W-1:0] rd_q;

    always_ff @(posedge pixclk or posedge rst) begin
      if (rst)
        rd_q <= '0;
      else if (lut_rd_en)
        rd_q <= mem[{lut_wr_bank, lut_wr_addr}];
    end

    assign rd_word[i*CH_W +: CH_W] = rd_q;
`else
    assign rd_word[i*CH_W +: CH_W] = '0;
`endif
  end

`ifdef RGB_LUT_REMAP_READBACK_EN
  logic [1:0] rd_ch_q;

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst)
      rd_ch_q <= '0;
    else if (lut_rd_en)
      rd_ch_q <= lut_wr_ch;
  end

  always_comb begin
    lut_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_q == 2'(i))
        lut_rd_data = rd_word[i*CH_W +: CH_W];
    end
  end
`else
  logic [PW-1:0] unused_rd_word;
  logic          unused_rd_en;
  assign unused_rd_word = rd_word;
  assign unused_rd_en   = lut_rd_en;
  assign lut_rd_data    = '0;
`endif

  logic [PW-1:0] pix_s1;
  logic          vld_s1;
  logic          vs_s1;
  logic          byp_s1;
  logic          inv_s1;
  logic [PW-1:0] out_nxt;

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      pix_s1 <= '0;
      vld_s1 <= 1'b0;
      vs_s1  <= 1'b0;
      byp_s1 <= 1'b0;
      inv_s1 <= 1'b0;
    end else begin
      pix_s1 <= vid_pData_in;
      vld_s1 <= vid_valid_in;
      vs_s1  <= vid_vsync_in;
      byp_s1 <= bypass | init_busy;
      inv_s1 <= invert;
    end
  end

  assign out_nxt = byp_s1 ? pix_s1 : (inv_s1 ? ~lut_word : lut_word);

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      vid_pData_out <= '0;
      vid_valid_out <= 1'b0;
      vid_vsync_out <= 1'b0;
    end else begin
      vid_pData_out <= out_nxt;
      vid_valid_out <= vld_s1;
      vid_vsync_out <= vs_s1;
    end
  end

endmodule

// File: tb/tb_rgb_lut_remap.sv
// Directed bench for rgb_lut_remap at default parameters (8-bit x 3 channels, 4 banks).
module tb_rgb_lut_remap;

  logic        pixclk;
  logic        rst;
  logic [23:0] vid_pData_in;
  logic        vid_valid_in;
  logic        vid_vsync_in;
  logic        bypass;
  logic        invert;
  logic [1:0]  bank_req;
  logic [23:0] vid_pData_out;
  logic        vid_valid_out;
  logic        vid_vsync_out;
  logic [1:0]  bank_active;
  logic        init_busy;
  logic        lut_wr_en;
  logic [1:0]  lut_wr_ch;
  logic [1:0]  lut_wr_bank;
  logic [7:0]  lut_wr_addr;
  logic [7:0]  lut_wr_data;
  logic        lut_wr_ready;
  logic        lut_rd_en;
  logic [7:0]  lut_rd_data;

  int tests;
  int fails;

`ifdef RGB_LUT_REMAP_READBACK_EN
  localparam logic [7:0] RB_MASK = 8'hFF;
`else
  localparam logic [7:0] RB_MASK = 8'h00;
`endif

  rgb_lut_remap dut (
    .pixclk        (pixclk),
    .rst           (rst),
    .vid_pData_in  (vid_pData_in),
    .vid_valid_in  (vid_valid_in),
    .vid_vsync_in  (vid_vsync_in),
    .bypass        (bypass),
    .invert        (invert),
    .bank_req      (bank_req),
    .vid_pData_out (vid_pData_out),
    .vid_valid_out (vid_valid_out),
    .vid_vsync_out (vid_vsync_out),
    .bank_active   (bank_active),
    .init_busy     (init_busy),
    .lut_wr_en     (lut_wr_en),
    .lut_wr_ch     (lut_wr_ch),
    .lut_wr_bank   (lut_wr_bank),
    .lut_wr_addr   (lut_wr_addr),
    .lut_wr_data   (lut_wr_data),
    .lut_wr_ready  (lut_wr_ready),
    .lut_rd_en     (lut_rd_en),
    .lut_rd_data   (lut_rd_data)
  );

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  task automatic tick;
    @(posedge pixclk);
    #1;
  endtask

  task automatic drive(input logic [23:0] p, input logic v, input logic vs);
    vid_pData_in = p;
    vid_valid_in = v;
    vid_vsync_in = vs;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] bank, input logic [7:0] addr, input logic [7:0] data);
    lut_wr_ch   = ch;
    lut_wr_bank = bank;
    lut_wr_addr = addr;
    lut_wr_data = data;
    lut_wr_en   = 1'b1;
    tick;
    lut_wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    tick;
    tests++; if (vid_pData_out !== 24'h0) begin fails++; $display("FAIL rst_pdata got %h want %h", vid_pData_out, 24'h0); end
    tests++; if (vid_valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", vid_valid_out); end
    tests++; if (vid_vsync_out !== 1'b0) begin fails++; $display("FAIL rst_vsync got %b want 0", vid_vsync_out); end
    tests++; if (bank_active !== 2'd0) begin fails++; $display("FAIL rst_bank got %0d want 0", bank_active); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL rst_init_busy got %b want 1", init_busy); end
    tests++; if (lut_wr_ready !== 1'b0) begin fails++; $display("FAIL rst_wr_ready got %b want 0", lut_wr_ready); end
    tests++; if (lut_rd_data !== 8'h00) begin fails++; $display("FAIL rst_rd_data got %h want 00", lut_rd_data); end
  endtask

  task automatic test_init;
    int n;
    rst = 1'b0;
    repeat (100) tick;
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL init_busy_mid got %b want 1", init_busy); end
    rst = 1'b1;
    tick;
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL init_rerst got %b want 1", init_busy); end
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 5000) begin
      if (n == 10) begin drive(24'h123456, 1'b1, 1'b0); invert = 1'b1; end
      if (n == 11) vid_valid_in = 1'b0;
      if (n == 200) begin lut_wr_ch = 2'd0; lut_wr_bank = 2'd0; lut_wr_addr = 8'h05; lut_wr_data = 8'hEE; lut_wr_en = 1'b1; end
      if (n == 201) lut_wr_en = 1'b0;
      tick;
      n++;
      if (n == 12) begin
        tests++; if (vid_pData_out !== 24'h123456) begin fails++; $display("FAIL init_force_bypass got %h want %h", vid_pData_out, 24'h123456); end
        tests++; if (vid_valid_out !== 1'b1) begin fails++; $display("FAIL init_valid got %b want 1", vid_valid_out); end
        tests++; if (lut_wr_ready !== 1'b0) begin fails++; $display("FAIL init_wr_ready got %b want 0", lut_wr_ready); end
      end
    end
    invert = 1'b0;
    tests++; if (n !== 1024) begin fails++; $display("FAIL init_length got %0d want %0d", n, 1024); end
    tests++; if (lut_wr_ready !== 1'b1) begin fails++; $display("FAIL run_wr_ready got %b want 1", lut_wr_ready); end
  endtask

  task automatic test_identity;
    drive(24'h123456, 1'b1, 1'b0);
    tick;
    tests++; if (vid_valid_out !== 1'b0) begin fails++; $display("FAIL ident_lat1_valid got %b want 0", vid_valid_out); end
    drive(24'h000005, 1'b1, 1'b0);
    tick;
    tests++; if (vid_pData_out !== 24'h123456) begin fails++; $display("FAIL ident_pix got %h want %h", vid_pData_out, 24'h123456); end
    tests++; if (vid_valid_out !== 1'b1) begin fails++; $display("FAIL ident_valid got %b want 1", vid_valid_out); end
    vid_valid_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h000005) begin fails++; $display("FAIL init_write_dropped got %h want %h", vid_pData_out, 24'h000005); end
    tick;
    tests++; if (vid_valid_out !== 1'b0) begin fails++; $display("FAIL ident_valid_fall got %b want 0", vid_valid_out); end
  endtask

  task automatic test_modes;
    wr(2'd0, 2'd0, 8'h56, 8'hA0);
    drive(24'h123456, 1'b1, 1'b0);
    tick;
    invert = 1'b1;
    tick;
    tests++; if (vid_pData_out !== 24'h1234A0) begin fails++; $display("FAIL mode_lut got %h want %h", vid_pData_out, 24'h1234A0); end
    bypass = 1'b1;
    tick;
    tests++; if (vid_pData_out !== 24'hEDCB5F) begin fails++; $display("FAIL mode_invert got %h want %h", vid_pData_out, 24'hEDCB5F); end
    bypass = 1'b0;
    invert = 1'b0;
    vid_valid_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h123456) begin fails++; $display("FAIL mode_bypass got %h want %h", vid_pData_out, 24'h123456); end
    tick;
  endtask

  task automatic test_ignore_ch3;
    wr(2'd3, 2'd0, 8'h12, 8'h99);
    drive(24'h121212, 1'b1, 1'b0);
    tick;
    vid_valid_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h121212) begin fails++; $display("FAIL ch3_ignored got %h want %h", vid_pData_out, 24'h121212); end
  endtask

  task automatic test_collision;
    drive(24'h007700, 1'b1, 1'b0);
    lut_wr_ch = 2'd1; lut_wr_bank = 2'd0; lut_wr_addr = 8'h77; lut_wr_data = 8'h3C; lut_wr_en = 1'b1;
    tick;
    lut_wr_en = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h007700) begin fails++; $display("FAIL collide_old got %h want %h", vid_pData_out, 24'h007700); end
    vid_valid_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h003C00) begin fails++; $display("FAIL collide_new got %h want %h", vid_pData_out, 24'h003C00); end
  endtask

  task automatic test_bank_switch;
    wr(2'd1, 2'd1, 8'h34, 8'h00);
    bank_req = 2'd1;
    drive(24'h123456, 1'b1, 1'b0);
    tick;
    tick;
    tests++; if (bank_active !== 2'd0) begin fails++; $display("FAIL bank_pending got %0d want 0", bank_active); end
    tests++; if (vid_pData_out !== 24'h1234A0) begin fails++; $display("FAIL bank_pre got %h want %h", vid_pData_out, 24'h1234A0); end
    vid_vsync_in = 1'b1;
    tick;
    tests++; if (bank_active !== 2'd1) begin fails++; $display("FAIL bank_switched got %0d want 1", bank_active); end
    tick;
    tests++; if (vid_pData_out !== 24'h1234A0) begin fails++; $display("FAIL bank_edge_pix got %h want %h", vid_pData_out, 24'h1234A0); end
    tests++; if (vid_vsync_out !== 1'b1) begin fails++; $display("FAIL vsync_delay got %b want 1", vid_vsync_out); end
    vid_vsync_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h120056) begin fails++; $display("FAIL bank_new_pix got %h want %h", vid_pData_out, 24'h120056); end
  endtask

  task automatic test_bank_toggle;
    bank_req = 2'd2;
    tick;
    bank_req = 2'd3;
    tick;
    tick;
    tests++; if (bank_active !== 2'd1) begin fails++; $display("FAIL toggle_hold got %0d want 1", bank_active); end
    vid_vsync_in = 1'b1;
    tick;
    tests++; if (bank_active !== 2'd3) begin fails++; $display("FAIL toggle_switch got %0d want 3", bank_active); end
    vid_vsync_in = 1'b0;
    tick;
    tests++; if (vid_pData_out !== 24'h120056) begin fails++; $display("FAIL toggle_edge_pix got %h want %h", vid_pData_out, 24'h120056); end
    tick;
    tests++; if (vid_pData_out !== 24'h123456) begin fails++; $display("FAIL toggle_bank3_pix got %h want %h", vid_pData_out, 24'h123456); end
    bank_req = 2'd0;
    tick;
    bank_req = 2'd3;
    tick;
    vid_vsync_in = 1'b1;
    tick;
    vid_vsync_in = 1'b0;
    tick;
    tick;
    tests++; if (bank_active !== 2'd3) begin fails++; $display("FAIL toggle_revert got %0d want 3", bank_active); end
    tests++; if (vid_pData_out !== 24'h123456) begin fails++; $display("FAIL toggle_revert_pix got %h want %h", vid_pData_out, 24'h123456); end
    vid_valid_in = 1'b0;
  endtask

  task automatic test_readback;
    wr(2'd2, 2'd3, 8'h10, 8'h7F);
    lut_wr_ch = 2'd2; lut_wr_bank = 2'd3; lut_wr_addr = 8'h10;
    lut_rd_en = 1'b1;
    tick;
    lut_rd_en = 1'b0;
    lut_wr_addr = 8'h11;
    tests++; if (lut_rd_data !== (8'h7F & RB_MASK)) begin fails++; $display("FAIL rd_data got %h want %h", lut_rd_data, 8'h7F & RB_MASK); end
    tick;
    tests++; if (lut_rd_data !== (8'h7F & RB_MASK)) begin fails++; $display("FAIL rd_hold got %h want %h", lut_rd_data, 8'h7F & RB_MASK); end
    lut_wr_addr = 8'h10; lut_wr_data = 8'h55;
    lut_wr_en = 1'b1;
    lut_rd_en = 1'b1;
    tick;
    lut_wr_en = 1'b0;
    tests++; if (lut_rd_data !== (8'h7F & RB_MASK)) begin fails++; $display("FAIL rd_prewrite got %h want %h", lut_rd_data, 8'h7F & RB_MASK); end
    tick;
    lut_rd_en = 1'b0;
    tests++; if (lut_rd_data !== (8'h55 & RB_MASK)) begin fails++; $display("FAIL rd_postwrite got %h want %h", lut_rd_data, 8'h55 & RB_MASK); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    drive(24'h0, 1'b0, 1'b0);
    bypass = 1'b0;
    invert = 1'b0;
    bank_req = 2'd0;
    lut_wr_en = 1'b0;
    lut_wr_ch = 2'd0;
    lut_wr_bank = 2'd0;
    lut_wr_addr = 8'h00;
    lut_wr_data = 8'h00;
    lut_rd_en = 1'b0;
    test_reset;
    test_init;
    test_identity;
    test_modes;
    test_ignore_ch3;
    test_collision;
    test_bank_switch;
    test_bank_toggle;
    test_readback;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_lut_remap.md
Name: rgb_lut_remap

Overview:
Per-channel colour remapper built on writable LUT RAMs, generalised to NUM_CH channels of CH_W bits with 2^BANK_BITS selectable curve banks per channel. It sits inline in the pixel path after the video source and before the mixer or output stage. Bank changes are frame-synchronous, applied on vsync. After reset it self-initialises every bank to identity.

Parameters:
CH_W, 8, bits per colour channel
NUM_CH, 3, channel count, 1..4; channel 0 is the LSBs of the pixel word
BANK_BITS, 2, log2 of the number of LUT banks per channel

Ports:
pixclk  in  1  pixel clock; the only clock
rst  in  1  asynchronous, active-high reset
vid_pData_in  in  NUM_CH*CH_W  pixel data in
vid_valid_in  in  1  pixel valid
vid_vsync_in  in  1  vertical sync in, active-high
bypass  in  1  pass input unchanged, latency-matched
invert  in  1  bitwise-invert the remapped output
bank_req  in  BANK_BITS  requested active bank
vid_pData_out  out  NUM_CH*CH_W  pixel data out
vid_valid_out  out  1  valid, aligned with data
vid_vsync_out  out  1  vsync, aligned with data
bank_active  out  BANK_BITS  bank currently used for lookup
init_busy  out  1  identity fill in progress
lut_wr_en  in  1  LUT write strobe
lut_wr_ch  in  2  target channel
lut_wr_bank  in  BANK_BITS  target bank
lut_wr_addr  in  CH_W  LUT entry index
lut_wr_data  in  CH_W  LUT entry value
lut_wr_ready  out  1  writes accepted when high
lut_rd_en  in  1  readback strobe (optional feature)
lut_rd_data  out  CH_W  readback data (optional feature)

Behaviour:
- Reset values: all outputs 0 except init_busy=1. Pipeline registers cleared. bank_active=0. FSM enters INIT.
- LUTs: one RAM per channel, depth 2^(BANK_BITS+CH_W), width CH_W. Address is {bank, index}.
- INIT state:
  - A counter sweeps 0..2^(BANK_BITS+CH_W)-1 and writes data = counter[CH_W-1:0] to every channel in parallel, one entry per cycle.
  - During INIT: init_busy=1, lut_wr_ready=0, external writes are dropped, and the datapath runs forced-bypass.
  - After the last address, go to RUN. init_busy falls on the next cycle.
- Reset asserted mid-INIT restarts INIT from address 0.
- RUN state: lut_wr_ready=1. A write with lut_wr_ch >= NUM_CH is ignored.
- Datapath, fixed latency 2 cycles:
  - Stage 1 registers the RAM read, the pixel, valid, vsync, bypass and invert.
  - Stage 2 registers the output.
  - Output is input pixel if bypass, else (invert ? ~lut : lut), per channel.
  - valid and vsync are delayed by 2 cycles regardless of mode.
  - The LUT read is performed every cycle irrespective of valid.
- Mode bits are sampled with the pixel, so a change takes effect on exactly the pixel presented in that cycle.
- Write/read collision (same channel, bank and index in the same cycle): RAM is read-first, so the pixel sees the old entry and the new value applies from the next cycle.
- Bank switch, two states IDLE/PENDING:
  - bank_req is compared with bank_active each cycle. On mismatch, latch bank_req as pending and go to PENDING.
  - In PENDING, on a rising edge of vid_vsync_in (current=1, previous=0), bank_active <= pending in that cycle, then return to IDLE.
  - If bank_req changes again while PENDING, the pending value updates. The last request before the edge wins.
  - If bank_req returns to bank_active before the edge, return to IDLE with no switch.
  - The new bank is used starting with the pixel presented on the cycle after the edge cycle.
- Writes to the active bank are permitted; tearing is the host's responsibility.

Optional Feature:
RGB_LUT_REMAP_READBACK_EN
- Defined: a second RAM read port on every channel.
  - lut_rd_en samples lut_wr_ch, lut_wr_bank and lut_wr_addr as the read address.
  - lut_rd_data is valid 1 cycle later and holds its value until the next lut_rd_en.
  - If lut_wr_en is asserted in the same cycle, the read returns the pre-write value.
- Undefined: lut_rd_en is ignored and lut_rd_data is tied to 0.
- Ports exist in both builds.

Test Plan:
- Reset, then wait: init_busy high for exactly 1024 cycles (defaults) then low; with pixel 0x123456 valid, output 0x123456 two cycles later.
- After init, write ch0 bank0 addr 0x56 = 0xA0, then drive 0x123456 -> 0x1234A0 at latency 2; set invert -> 0xEDCB5F; set bypass -> 0x123456.
- bank_req=1 mid-frame with bank1 ch1 addr 0x34=0x00: output unchanged until the cycle after the vsync rising edge, then 0x120056. bank_active reads 1 from that cycle on.
- bank_req toggles 0->2->3 before vsync: a single switch to 3 at the edge. Toggle 1->0 before the edge: no switch.
- lut_wr_en during INIT is dropped (entry remains identity). Write with lut_wr_ch=3 when NUM_CH=3 has no effect. Collision write on the active address: that pixel shows the old value, the next pixel the new value.
- READBACK_EN: write 0x7F to ch2 bank3 addr 0x10, read back -> 0x7F one cycle after lut_rd_en. Without the macro -> 0x00.
